// File: rtl/fir_stream_ctrl.sv
// Valid/ready streaming front-end for the serial FIR engine: input FIFO, start/done sequencing, output register.
// Define FIR_STREAM_CTRL_TIMEOUT_EN to enable the WAIT-state watchdog and the sticky err flag.
module fir_stream_ctrl #(
  parameter int unsigned DataWidth     = 12,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_data,
  output logic                 fir_start,
  output logic [DataWidth-1:0] fir_x,
  input  logic                 fir_done,
  input  logic [DataWidth-1:0] fir_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_data,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_HOLD
  } state_e;

  generate
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
      $error("fir_stream_ctrl: FifoDepth must be a power of two and at least 2");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
      $error("fir_stream_ctrl: TimeoutCycles must be at least 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;

  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 fifo_full, fifo_empty;
  logic                 fifo_wr, fifo_rd;

  logic [DataWidth-1:0] fir_x_q, fir_x_d;
  logic                 out_valid_q, out_valid_d;
  logic [DataWidth-1:0] out_data_q, out_data_d;

  logic                 out_free;
  logic                 load_out;
  logic                 timeout;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  assign fifo_full  = (count_q == CntW'(FifoDepth));
  assign fifo_empty = (count_q == '0);
  assign fifo_wr    = in_valid && !fifo_full;
  assign in_ready   = !fifo_full;

  // NOTE: storage has no reset; only the pointers and count must be defined, so the RAM stays reset-free.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // NOTE: every variable assigned in an always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (fifo_rd) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(fifo_wr) - CntW'(fifo_rd);
  end

  // ---------------------------------------------------------------------------
  // Control FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  assign out_free = !out_valid_q || out_ready;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : fsm_next_state
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (fir_done) begin
          state_d = out_free ? S_IDLE : S_HOLD;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (out_free) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A done seen outside WAIT never loads, which also drops stale dones after reset.
  always_comb begin : fsm_outputs
    fir_start = 1'b0;
    fifo_rd   = 1'b0;
    load_out  = 1'b0;
    case (state_q)
      S_IDLE:  fifo_rd   = !fifo_empty;
      S_START: fir_start = 1'b1;
      S_WAIT:  load_out  = fir_done && out_free;
      S_HOLD:  load_out  = out_free;
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Sample and output registers
  // ---------------------------------------------------------------------------
  always_comb begin
    fir_x_d     = fir_x_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (fifo_rd) begin
      fir_x_d = mem_q[rd_ptr_q];
    end
    if (load_out) begin
      out_valid_d = 1'b1;
      out_data_d  = fir_y;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fir_x_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fir_x_q     <= fir_x_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign fir_x     = fir_x_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // ---------------------------------------------------------------------------
  // Optional WAIT watchdog
  // ---------------------------------------------------------------------------
`ifdef FIR_STREAM_CTRL_TIMEOUT_EN
  localparam int unsigned TimerW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  logic [TimerW-1:0] timer_q, timer_d;
  logic              err_q, err_d;

  // A late done on the final cycle still wins over the timeout.
  assign timeout = (state_q == S_WAIT) && !fir_done &&
                   (timer_q == TimerW'(TimeoutCycles - 1));

  // Held at zero outside WAIT, so each WAIT entry starts a fresh count.
  always_comb begin
    timer_d = '0;
    if (state_q == S_WAIT && !timeout) begin
      timer_d = timer_q + TimerW'(1);
    end
    err_d = err_q || timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl with a behavioural FIR engine stub (fixed latency, y = x or x/2).
// Define FIR_STREAM_CTRL_TIMEOUT_EN for both RTL and bench to exercise the watchdog.
module tb_fir_stream_ctrl;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          fir_start;
  logic [DW-1:0] fir_x;
  logic          fir_done = 1'b0;
  logic [DW-1:0] fir_y = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          err;

  int errors = 0;
  int checks = 0;

  fir_stream_ctrl #(
    .DataWidth    (DW),
    .FifoDepth    (4),
    .TimeoutCycles(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .fir_start(fir_start),
    .fir_x    (fir_x),
    .fir_done (fir_done),
    .fir_y    (fir_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Engine stub: latches fir_x on a start, answers after stub_latency negedges unless stalled.
  // It deliberately ignores rst, so an operation in flight at reset answers afterwards.
  int                   stub_latency = 3;
  bit                   stub_stall   = 1'b0;
  bit                   stub_halve   = 1'b1;
  bit                   stub_pending = 1'b0;
  int                   stub_cnt     = 0;
  logic signed [DW-1:0] stub_x       = '0;
  int                   start_cnt    = 0;

  always @(negedge clk) begin
    fir_done = 1'b0;
    if (stub_pending && !stub_stall) begin
      if (stub_cnt <= 1) begin
        fir_done     = 1'b1;
        fir_y        = stub_halve ? (stub_x >>> 1) : stub_x;
        stub_pending = 1'b0;
      end else begin
        stub_cnt--;
      end
    end
    if (fir_start) begin
      stub_pending = 1'b1;
      stub_x       = fir_x;
      stub_cnt     = stub_latency;
    end
  end

  always @(posedge clk) begin
    if (fir_start) start_cnt++;
  end

  // Output collector: records every accepted output beat.
  logic [DW-1:0] got_q[$];

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("output_count", 32'(got_q.size()), 32'(n));
  endtask

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int k;
    int start_base;
    bit saw_valid;

    // y = x/2 with arithmetic shift, computed by hand
    vecs[0] = '{x: 12'h400, y: 12'h200};
    vecs[1] = '{x: 12'h7FF, y: 12'h3FF};
    vecs[2] = '{x: 12'h800, y: 12'hC00};
    vecs[3] = '{x: 12'hFFF, y: 12'hFFF};
    vecs[4] = '{x: 12'h001, y: 12'h000};
    vecs[5] = '{x: 12'h555, y: 12'h2AA};
    vecs[6] = '{x: 12'hAAA, y: 12'hD55};

    // ---- Reset values ----
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_fir_start", 32'(fir_start), 32'd0);
    check("rst_fir_x",     32'(fir_x),     32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_err",       32'(err),       32'd0);

    // ---- Single sample, 60-cycle engine, y = x/2 ----
    stub_latency = 60;
    stub_halve   = 1'b1;
    out_ready    = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'h400;
    @(negedge clk);
    in_valid = 1'b0;
    check("single_idle_after_accept", 32'(busy),      32'd0);
    check("single_no_start_yet",      32'(fir_start), 32'd0);
    @(negedge clk);
    check("single_start_after_pop",   32'(fir_start), 32'd1);
    check("single_fir_x",             32'(fir_x),     32'h400);
    @(negedge clk);
    check("single_start_one_cycle",   32'(fir_start), 32'd0);
    check("single_waiting_busy",      32'(busy),      32'd1);
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_out_data",  32'(out_data),  32'h200);
    check("single_back_idle", 32'(busy),      32'd0);
    wait_outputs(1);
    check("single_collected", 32'(got_q[0]), 32'h200);
    got_q.delete();

    // ---- Table-driven stream ----
    stub_latency = 3;
    foreach (vecs[i]) push(vecs[i].x);
    wait_outputs($size(vecs));
    for (int i = 0; i < $size(vecs); i++) begin
      check($sformatf("table_y[%0d]", i), 32'(got_q[i]), 32'(vecs[i].y));
    end
    got_q.delete();

    // ---- FIFO full with stalled engine, pass-through y = x ----
    // Sample 1 is popped into the stalled engine, so samples 2..5 fill the four entries.
    stub_halve = 1'b0;
    stub_stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'(i);
      check($sformatf("full_ready_before_%0d", i), 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    in_data = 12'h006;
    check("full_in_ready_low", 32'(in_ready), 32'd0);
    cycles(5);
    check("full_sample6_held", 32'(in_ready), 32'd0);
    check("full_engine_busy",  32'(busy),     32'd1);
    stub_stall = 1'b0;
    k = 0;
    while (!in_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_outputs(6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("full_order[%0d]", i), 32'(got_q[i]), 32'(i + 1));
    end
    got_q.delete();

    // ---- Output backpressure: second result parks in HOLD ----
    out_ready  = 1'b0;
    start_base = start_cnt;
    push(12'h0A1);
    push(12'h0B2);
    push(12'h0C3);
    cycles(30);
    check("bp_out_valid",     32'(out_valid),              32'd1);
    check("bp_first_held",    32'(out_data),               32'h0A1);
    check("bp_hold_busy",     32'(busy),                   32'd1);
    check("bp_two_starts",    32'(start_cnt - start_base), 32'd2);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_reload_valid",  32'(out_valid),              32'd1);
    check("bp_second_loaded", 32'(out_data),               32'h0B2);
    check("bp_still_two",     32'(start_cnt - start_base), 32'd2);
    @(negedge clk);
    check("bp_third_start",   32'(fir_start),              32'd1);
    check("bp_third_x",       32'(fir_x),                  32'h0C3);
    out_ready = 1'b1;
    wait_outputs(3);
    check("bp_order0", 32'(got_q[0]), 32'h0A1);
    check("bp_order1", 32'(got_q[1]), 32'h0B2);
    check("bp_order2", 32'(got_q[2]), 32'h0C3);
    got_q.delete();

    // ---- Reset mid-WAIT, stale done afterwards ----
    stub_latency = 12;
    push(12'h123);
    cycles(3);
    check("rw_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    cycles(2);
    check("rw_busy_in_reset",  32'(busy),      32'd0);
    check("rw_valid_in_reset", 32'(out_valid), 32'd0);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("rw_stale_done_ignored", 32'(saw_valid),    32'd0);
    check("rw_idle",               32'(busy),         32'd0);
    check("rw_no_output",          32'(got_q.size()), 32'd0);
    push(12'h321);
    wait_outputs(1);
    check("rw_after_reset_sample", 32'(got_q[0]), 32'h321);
    got_q.delete();

`ifdef FIR_STREAM_CTRL_TIMEOUT_EN
    // ---- Watchdog: engine never answers the first sample ----
    stub_stall = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 12'h111;
    @(negedge clk);
    in_data  = 12'h222;
    @(negedge clk);
    in_valid = 1'b0;
    check("to_first_start", 32'(fir_start), 32'd1);
    check("to_first_x",     32'(fir_x),     32'h111);
    @(negedge clk);
    cycles(15);
    check("to_err_not_yet", 32'(err),  32'd0);
    check("to_still_wait",  32'(busy), 32'd1);
    @(negedge clk);
    check("to_err_set",     32'(err),  32'd1);
    check("to_back_idle",   32'(busy), 32'd0);
    @(negedge clk);
    check("to_next_start",  32'(fir_start), 32'd1);
    check("to_next_x",      32'(fir_x),     32'h222);
    stub_stall = 1'b0;
    wait_outputs(1);
    check("to_next_result", 32'(got_q[0]), 32'h222);
    check("to_err_sticky",  32'(err),      32'd1);
    got_q.delete();
`else
    // ---- Without the watchdog WAIT lasts as long as the engine does ----
    stub_stall = 1'b1;
    push(12'h111);
    cycles(40);
    check("nto_still_wait", 32'(busy),      32'd1);
    check("nto_err_low",    32'(err),       32'd0);
    check("nto_no_output",  32'(out_valid), 32'd0);
    stub_stall = 1'b0;
    wait_outputs(1);
    check("nto_result",     32'(got_q[0]),  32'h111);
    check("nto_err_still",  32'(err),       32'd0);
    got_q.delete();
`endif

    cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
